// File: rtl/misuratore_impulsi_pkg.sv
// Shared constants for the pulse-width measurer: handshake FSM encodings,
// default measurement width and its saturation value.
package misuratore_impulsi_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [W_DEFAULT-1:0] SATURAZIONE = '1;

  localparam logic [1:0] ATTESA_SOC      = 2'd0;
  localparam logic [1:0] ATTESA_FINE_SOC = 2'd1;
  localparam logic [1:0] ATTESA_MISURA   = 2'd2;

endpackage

// File: rtl/misuratore_impulsi_contatore.sv
// contatore_impulsi: counts armed high phases of impulso and holds the latest
// completed count in a one-entry buffer tagged by fresh. MISURATORE_OVR_EN adds the overwrite strobe.
module contatore_impulsi
  import misuratore_impulsi_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         impulso,
  input  logic         consume,
  output logic         fresh,
  output logic [W-1:0] buffer
`ifdef MISURATORE_OVR_EN
  ,
  output logic         overwrite
`endif
);

  localparam logic [W-1:0] MAX = '1;

  logic         armed_q, armed_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] buf_q, buf_d;
  logic         fresh_q, fresh_d;
  logic         cattura;

  // A non-zero count implies a completed high phase seen while armed.
  always_comb begin
    cattura = armed_q && !impulso && (cnt_q != '0);
    armed_d = armed_q | ~impulso;
    cnt_d   = cnt_q;
    if (armed_q && impulso)
      cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + W'(1);
    else if (cattura)
      cnt_d = '0;
    buf_d   = cattura ? cnt_q : buf_q;
    fresh_d = cattura | (fresh_q & ~consume);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
      buf_q   <= '0;
      fresh_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fresh_q <= fresh_d;
    end
  end

  assign fresh  = fresh_q;
  assign buffer = buf_q;

`ifdef MISURATORE_OVR_EN
  assign overwrite = cattura & fresh_q;
`endif

endmodule

// File: rtl/misuratore_impulsi.sv
// Pulse-width measurer serving results as the responder of the soc/eoc handshake.
// Define MISURATORE_OVR_EN to add the ovr lost-measurement flag.
module misuratore_impulsi
  import misuratore_impulsi_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         impulso,
  input  logic         soc,
  output logic         eoc,
  output logic [W-1:0] numero
`ifdef MISURATORE_OVR_EN
  ,
  output logic         ovr
`endif
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] numero_q, numero_d;
  logic         consegna;
  logic         fresh;
  logic [W-1:0] buffer;

`ifdef MISURATORE_OVR_EN
  logic overwrite;
  logic ovr_q, ovr_d;
`endif

  contatore_impulsi #(.W(W)) u_contatore (
    .clock    (clock),
    .reset_   (reset_),
    .impulso  (impulso),
    .consume  (consegna),
    .fresh    (fresh),
    .buffer   (buffer)
`ifdef MISURATORE_OVR_EN
    ,
    .overwrite(overwrite)
`endif
  );

  always_comb begin
    state_d  = state_q;
    consegna = 1'b0;
    case (state_q)
      ATTESA_SOC: begin
        if (soc) state_d = ATTESA_FINE_SOC;
      end
      ATTESA_FINE_SOC: begin
        if (!soc) begin
          if (fresh) begin
            consegna = 1'b1;
            state_d  = ATTESA_SOC;
          end else begin
            state_d  = ATTESA_MISURA;
          end
        end
      end
      ATTESA_MISURA: begin
        if (fresh) begin
          consegna = 1'b1;
          state_d  = ATTESA_SOC;
        end
      end
      default: state_d = ATTESA_SOC;
    endcase
    numero_d = consegna ? buffer : numero_q;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ATTESA_SOC;
      numero_q <= '0;
    end else begin
      state_q  <= state_d;
      numero_q <= numero_d;
    end
  end

  assign eoc    = (state_q == ATTESA_SOC);
  assign numero = numero_q;

`ifdef MISURATORE_OVR_EN
  // Overwrite wins over a clearing deliver on the same edge.
  always_comb begin
    ovr_d = ovr_q;
    if (overwrite)     ovr_d = 1'b1;
    else if (consegna) ovr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) ovr_q <= 1'b0;
    else         ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_misuratore_impulsi.sv
// Directed self-checking bench for misuratore_impulsi (W=8).
module tb_misuratore_impulsi;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset_;
  logic         impulso;
  logic         soc;
  logic         eoc;
  logic [W-1:0] numero;
`ifdef MISURATORE_OVR_EN
  logic         ovr;
`endif

  int unsigned n_check;
  int unsigned n_err;

  misuratore_impulsi #(.W(W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .impulso(impulso),
    .soc    (soc),
    .eoc    (eoc),
    .numero (numero)
`ifdef MISURATORE_OVR_EN
    ,
    .ovr    (ovr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] oss, input logic [31:0] att);
    n_check++;
    if (oss !== att) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, oss, att);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // n high samples, then one low sample (the capture edge)
  task automatic impulso_alto(input int n);
    impulso = 1'b1;
    repeat (n) tick();
    impulso = 1'b0;
    tick();
  endtask

  // Full soc/eoc cycle; attese = extra cycles spent waiting after soc fell
  task automatic ciclo_soc(input string tag, input logic [W-1:0] atteso, output int attese);
    soc = 1'b1;
    tick();
    verifica({tag, "_eoc_basso"}, 32'(eoc), 32'd0);
    soc = 1'b0;
    tick();
    attese = 0;
    while (!eoc && attese < 50) begin
      tick();
      attese++;
    end
    verifica({tag, "_eoc_alto"}, 32'(eoc), 32'd1);
    verifica({tag, "_numero"}, 32'(numero), 32'(atteso));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_check = 0;
    n_err   = 0;
    reset_  = 1'b0;
    impulso = 1'b1;
    soc     = 1'b0;

    // Reset with impulso held high; partial phase must be discarded
    repeat (3) tick();
    verifica("reset_eoc", 32'(eoc), 32'd1);
    verifica("reset_numero", 32'(numero), 32'd0);
`ifdef MISURATORE_OVR_EN
    verifica("reset_ovr", 32'(ovr), 32'd0);
`endif
    reset_ = 1'b1;
    repeat (4) tick();
    impulso = 1'b0;
    tick();
    soc = 1'b1;
    tick();
    verifica("t1_eoc_dopo_soc", 32'(eoc), 32'd0);
    soc = 1'b0;
    repeat (4) tick();
    verifica("t1_parziale_scartato", 32'(eoc), 32'd0);
    impulso_alto(5);
    verifica("t1_eoc_al_capture", 32'(eoc), 32'd0);
    tick();
    verifica("t1_eoc", 32'(eoc), 32'd1);
    verifica("t1_numero", 32'(numero), 32'd5);

    // Sequence of phases, each with its own handshake
    impulso_alto(6);
    verifica("t2_eoc_idle_a", 32'(eoc), 32'd1);
    ciclo_soc("t2_6", 8'd6, w);
    impulso_alto(10);
    verifica("t2_eoc_idle_b", 32'(eoc), 32'd1);
    ciclo_soc("t2_10", 8'd10, w);
    impulso_alto(25);
    verifica("t2_eoc_idle_c", 32'(eoc), 32'd1);
    ciclo_soc("t2_25", 8'd25, w);
    verifica("t2_numero_stabile", 32'(numero), 32'd25);

    // Async reset mid-handshake
    soc = 1'b1;
    tick();
    verifica("t3_fine_soc", 32'(eoc), 32'd0);
    reset_ = 1'b0;
    #1;
    verifica("t3_reset_eoc", 32'(eoc), 32'd1);
    verifica("t3_reset_numero", 32'(numero), 32'd0);
    soc = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();

    // soc before any measurement: wait in ATTESA_MISURA
    soc = 1'b1;
    tick();
    soc = 1'b0;
    repeat (5) tick();
    verifica("t3_attesa_misura", 32'(eoc), 32'd0);
    impulso_alto(7);
    verifica("t3_eoc_al_capture", 32'(eoc), 32'd0);
    tick();
    verifica("t3_eoc", 32'(eoc), 32'd1);
    verifica("t3_numero", 32'(numero), 32'd7);

    // Saturation
    impulso_alto(300);
    ciclo_soc("t4_sat", 8'd255, w);

    // Overwrite: newest value wins
    impulso_alto(3);
`ifdef MISURATORE_OVR_EN
    verifica("t5_ovr_prima", 32'(ovr), 32'd0);
`endif
    impulso_alto(4);
`ifdef MISURATORE_OVR_EN
    verifica("t5_ovr", 32'(ovr), 32'd1);
`endif
    ciclo_soc("t5_sovr", 8'd4, w);
`ifdef MISURATORE_OVR_EN
    verifica("t5_ovr_pulito", 32'(ovr), 32'd0);
`endif

    // Capture on the same edge as a deliver
    impulso_alto(9);
    soc = 1'b1;
    tick();
    verifica("t6_fine_soc", 32'(eoc), 32'd0);
    impulso = 1'b1;
    repeat (12) tick();
    verifica("t6_attesa", 32'(eoc), 32'd0);
    impulso = 1'b0;
    soc     = 1'b0;
    tick();
    verifica("t6_eoc", 32'(eoc), 32'd1);
    verifica("t6_vecchio", 32'(numero), 32'd9);
`ifdef MISURATORE_OVR_EN
    verifica("t6_ovr", 32'(ovr), 32'd1);
`endif
    ciclo_soc("t6_nuovo", 8'd12, w);
    verifica("t6_senza_attesa", 32'(w), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_check, n_err);
    $finish;
  end

endmodule

// File: doc/misuratore_impulsi.md
# misuratore_impulsi

Pulse-width measurer that serves its measurements as the responder (producer) end of the soc/eoc handshake. It counts how many clock cycles each high phase of `impulso` lasts, keeps the latest completed count in a one-entry buffer, and delivers it on `numero` when a consumer runs a soc/eoc cycle. It sits upstream of the pulse-forming block and drives that block's `numero`/`eoc` inputs from its `soc` output.

## Interface
- `W`, 8, width of `numero` and of the internal counter
- `clock`  input  1  system clock, all logic on posedge
- `reset_`  input  1  asynchronous, active-low reset
- `impulso`  input  1  pulse under measurement; synchronous to `clock`, no synchronizer in this block
- `soc`  input  1  start-of-conversion request from the consumer
- `eoc`  output  1  end-of-conversion; 1 = `numero` valid, idle
- `numero`  output  W  last delivered measurement, in clock cycles
- `ovr`  output  1  lost-measurement flag (only with `MISURATORE_OVR_EN`)

## Operation
- Reset: `eoc`=1, `numero`=0, `ovr`=0, buffer empty (`fresh`=0), counter 0, `armed`=0.
- Arming: a high phase counts only if `impulso`=0 has been sampled since reset. A phase already in progress at reset release is discarded.
- Measurement: each posedge sampling `impulso`=1 while armed increments the counter. The count starts at 1 on the first high sample and saturates at 2^W-1.
- Capture: the first posedge sampling `impulso`=0 after a high phase writes the count to the buffer, sets `fresh`=1 and clears the counter. A high phase of N samples yields N.
- Handshake FSM:
  - ATTESA_SOC: `eoc`=1. On `soc`=1, go to ATTESA_FINE_SOC with `eoc`=0.
  - ATTESA_FINE_SOC: `eoc`=0. On `soc`=0, if `fresh`, deliver; otherwise go to ATTESA_MISURA.
  - ATTESA_MISURA: `eoc`=0. When `fresh`=1, deliver.
  - Deliver: `numero`←buffer, `eoc`←1, `fresh`←0, next state ATTESA_SOC.
- Each measurement is delivered at most once. A consumer may therefore wait arbitrarily long with `eoc`=0.
- Capture and deliver on the same edge: the delivered value is the old buffer content. The new count goes into the buffer and `fresh` stays 1.
- Capture while `fresh`=1 and not delivering: the buffer is overwritten, so the newest value wins.
- `soc` pulled back to 0 before `eoc` falls is a protocol violation. The FSM still follows the rules above.
- Reset mid-operation returns every register to its reset value immediately.

## Timing
- `soc`=1 sampled at edge k: `eoc`=0 after edge k.
- `soc`=0 sampled at edge m with `fresh`=1: `numero` valid and `eoc`=1 after edge m, in the same cycle.
- Without `fresh`: `eoc` rises after the edge following the capture edge.
- `numero` is stable from the rise of `eoc` until the next delivery.
- Capture latency: the buffer is valid one cycle after the falling edge of `impulso` is sampled.

## Configuration
- `MISURATORE_OVR_EN` defined:
  - `ovr` port present.
  - `ovr` is set when a capture overwrites a `fresh` buffer, including when that capture coincides with a deliver of the old value.
  - `ovr` is cleared on the next deliver that involves no overwrite.
- Not defined: no `ovr` port; overwrites are silent.

## Structure
- Shared package/include holds:
  - the FSM state encodings ATTESA_SOC, ATTESA_FINE_SOC, ATTESA_MISURA;
  - the default width constant `W`=8;
  - the saturation value.
- One sub-module, `contatore_impulsi`. It contains `armed`, the counter, the buffer and `fresh`. It exports the `fresh`/buffer pair and takes a `consume` strobe from the handshake FSM in the top.

## Test plan
- Reset with `impulso`=1 held, release, then 5 high cycles, `impulso` to 0, run soc/eoc:
  - the partial phase is discarded;
  - after the first low sample, then 5 high samples and a low, `numero`=5.
- High phases 6, 10, 25, each followed by a full soc/eoc cycle → `numero` = 6, 10, 25 in order, and `eoc` stays 1 between cycles.
- `soc` raised before any measurement exists → `eoc` stays 0 through ATTESA_MISURA. It rises the cycle after capture of a 7-cycle phase, with `numero`=7.
- High phase of 300 cycles with W=8 → `numero`=255.
- Phases 3 then 4 with no soc in between, then one soc/eoc cycle:
  - `numero`=4;
  - with `MISURATORE_OVR_EN`, `ovr`=1 after the second capture.
- Capture on the same edge as a deliver:
  - deliver returns the old value 9;
  - the next soc/eoc cycle returns the new value 12 without waiting.
